request_encoder_ctrl: RTL
=========================

REQUEST_ENCODER_CTRL -- requirements
Module: request_encoder_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15, range 1..255: cycles Valid_Out may stay high without Ready_In before the grant is dropped.
REQ-002 Clock_In  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset_n_In  input  1  reset, asynchronous assert, active-low.
REQ-004 Enable_In  input  1  high = capture requests and issue grants.
REQ-005 Data_0_In .. Data_7_In  input  1 each  request lines; index = line number.
REQ-006 Ready_In  input  1  consumer accepts the presented code.
REQ-007 Valid_Out  output  1  Encoded_Value_Out holds a valid grant.
REQ-008 Encoded_Value_Out  output  3  index of the granted request.
REQ-009 Pending_Out  output  8  registered pending-request vector; bit i = line i.
REQ-010 Timeout_Out  output  1  one-cycle pulse when a grant is dropped after MAX_WAIT.

Function
REQ-011 Capture: with Enable_In high, pending[i] SHALL set on each edge where Data_i_In is high; bits stay sticky until granted-and-accepted or timed out.
REQ-012 Priority: the lowest pending index SHALL win; bit 0 is highest priority.
REQ-013 FSM states SHALL be IDLE and VALID.
REQ-014 IDLE to VALID: on an edge with Enable_In high and pending non-zero, the winner index SHALL be registered into Encoded_Value_Out, and Valid_Out SHALL be high from the next cycle.
REQ-015 In VALID, Encoded_Value_Out SHALL stay stable regardless of newly arriving higher-priority requests.
REQ-016 VALID with Ready_In high: the granted pending bit SHALL clear, the FSM SHALL return to IDLE, and Valid_Out SHALL be low the next cycle.
- Maximum throughput is one grant per 2 cycles.
REQ-017 Wait counter (8-bit): SHALL reset to 0 on entry to VALID and increment on each VALID cycle with Ready_In low.
- When the counter reaches MAX_WAIT, Timeout_Out SHALL pulse for one cycle, the granted bit SHALL clear, and the FSM SHALL go to IDLE.
- Ready_In on the same cycle as the timeout SHALL count as accept; Timeout_Out stays low.
REQ-018 Set and clear of the same pending bit on one edge: set SHALL win, so the request stays pending.
REQ-019 Enable_In low: no captures and no new grants; an in-flight VALID SHALL still complete or time out, and pending bits SHALL be retained.
REQ-020 Encoded_Value_Out SHALL read 3'd0 whenever Valid_Out is low; outputs SHALL never be X or Z after reset.
REQ-021 Ready_In while in IDLE SHALL be ignored.

Reset
REQ-022 Reset_n_In low SHALL asynchronously force: FSM to IDLE, pending to 8'h00, counter to 0, Valid_Out to 0, Encoded_Value_Out to 0, Timeout_Out to 0.
REQ-023 Reset mid-grant SHALL discard the grant and all pending bits; there SHALL be no Timeout_Out pulse.
REQ-024 First capture after deassertion SHALL occur on the first rising edge with Reset_n_In high.

Configuration
REQ-025 Macro REQUEST_ENCODER_MASK_EN, when defined, SHALL add port Mask_In (input, 8 bits).
- A bit set in Mask_In excludes that line from winner selection; its pending bit is still captured and retained.
- The mask does not affect an in-flight VALID.
REQ-026 Without the macro there SHALL be no Mask_In port, and all lines SHALL be eligible.

Structure
REQ-027 Package request_encoder_pkg SHALL hold NUM_REQ = 8, CODE_W = 3, and the FSM state enum (IDLE, VALID).
REQ-028 Winner selection SHALL live in combinational sub-module lowest_index_encoder_8_3.
- Inputs: 8-bit vector. Outputs: 3-bit index and a 1-bit any-set flag.

Verification
REQ-029 Reset, then pulse Data_5_In for one cycle with Enable_In = 1 and Ready_In = 1 → Valid_Out high for 1 cycle, Encoded_Value_Out = 5, Pending_Out returns to 8'h00.
REQ-030 Set Data_6_In, Data_2_In and Data_3_In simultaneously, Ready_In = 1 → grants in the order 2, 3, 6, one every 2 cycles.
REQ-031 Hold Ready_In = 0 with MAX_WAIT = 15 and a request on line 1 → Valid_Out high for exactly 15 cycles, then a Timeout_Out pulse, and pending[1] = 0.
REQ-032 Assert Data_0_In while code 4 is presented → Encoded_Value_Out stays 4 until accept; the next grant is 0.
REQ-033 Drop Reset_n_In mid-VALID → all outputs 0 immediately (asynchronous); no Timeout_Out pulse.
REQ-034 With the mask macro, Mask_In = 8'h01 and lines 0 and 7 requesting → grant 7; pending[0] stays set.

Source files
------------

// File: rtl/request_encoder_pkg.sv
// rtl/request_encoder_pkg.sv - shared widths and FSM state type for the request encoder
package request_encoder_pkg;
    localparam int NUM_REQ = 8;
    localparam int CODE_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;
endpackage

// File: rtl/lowest_index_encoder_8_3.sv
// rtl/lowest_index_encoder_8_3.sv - combinational 8:3 encoder, lowest set bit wins
module lowest_index_encoder_8_3
    import request_encoder_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_vec,
    output logic [CODE_W-1:0]  index,
    output logic               any_set
);

    // Scan downward so the last assignment is the lowest set index.
    always_comb begin
        index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                index = CODE_W'(i);
            end
        end
    end

    assign any_set = |req_vec;

endmodule

// File: rtl/request_encoder_ctrl.sv
// rtl/request_encoder_ctrl.sv - sticky request capture, priority grant with ready/timeout handshake
// Optional Mask_In port enabled by defining REQUEST_ENCODER_MASK_EN.
module request_encoder_ctrl
    import request_encoder_pkg::*;
#(
    parameter int MAX_WAIT = 15
)
(
    input  logic               Clock_In,
    input  logic               Reset_n_In,
    input  logic               Enable_In,
    input  logic               Data_0_In,
    input  logic               Data_1_In,
    input  logic               Data_2_In,
    input  logic               Data_3_In,
    input  logic               Data_4_In,
    input  logic               Data_5_In,
    input  logic               Data_6_In,
    input  logic               Data_7_In,
`ifdef REQUEST_ENCODER_MASK_EN
    input  logic [NUM_REQ-1:0] Mask_In,
`endif
    input  logic               Ready_In,
    output logic               Valid_Out,
    output logic [CODE_W-1:0]  Encoded_Value_Out,
    output logic [NUM_REQ-1:0] Pending_Out,
    output logic               Timeout_Out
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  pending_q, pending_d;
    logic [NUM_REQ-1:0]  req_in, eligible, clr;
    logic [CODE_W-1:0]   code_q, code_d, win_idx;
    logic [7:0]          wait_q, wait_d;
    logic                timeout_q, timeout_d;
    logic                win_any;

    assign req_in = {Data_7_In, Data_6_In, Data_5_In, Data_4_In,
                     Data_3_In, Data_2_In, Data_1_In, Data_0_In};

`ifdef REQUEST_ENCODER_MASK_EN
    assign eligible = pending_q & ~Mask_In;
`else
    assign eligible = pending_q;
`endif

    lowest_index_encoder_8_3 u_enc (
        .req_vec (eligible),
        .index   (win_idx),
        .any_set (win_any)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        wait_d    = wait_q;
        timeout_d = 1'b0;
        clr       = '0;
        case (state_q)
            IDLE: begin
                if (Enable_In && win_any) begin
                    state_d = VALID;
                    code_d  = win_idx;
                    wait_d  = 8'd0;
                end
            end
            VALID: begin
                // Ready on the final wait cycle is an accept, not a timeout.
                if (Ready_In || (wait_q == WAIT_LAST)) begin
                    clr       = NUM_REQ'(1) << code_q;
                    timeout_d = ~Ready_In;
                    state_d   = IDLE;
                    code_d    = '0;
                    wait_d    = 8'd0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
            end
        endcase
        // New capture is OR-ed after the clear so a same-edge set wins.
        pending_d = (pending_q & ~clr) | (Enable_In ? req_in : '0);
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign Valid_Out         = (state_q == VALID);
    assign Encoded_Value_Out = code_q;
    assign Pending_Out       = pending_q;
    assign Timeout_Out       = timeout_q;

endmodule
